bf_out_route_sched: RTL and testbench

//  Sequences one NTT/INTT pass over the dual-butterfly core.
//  - Per issue cycle: generates the four 2-bit output-routing selects plus the NTT/INTT mode bit for the butterfly-output network.
//  - Counts groups and stages.
//  - Inserts a pipeline-drain gap after each stage, sized to the network's 7-cycle NTT / 13-cycle INTT select delay.

---
 rtl/bf_out_route_sched.sv | 133 +++++++++++++
 tb/tb_bf_out_route_sched.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/bf_out_route_sched.sv
// Pass sequencer for the dual-butterfly core: issues groups, counts stages, drains the output network.
// Optional BF_OUT_SCHED_STALL_EN adds a hold input that freezes issue while in RUN.
module bf_out_route_sched #(
  parameter int GRP_W        = 7,
  parameter int NUM_STAGES   = 9,
  parameter int STAGE_W      = 4,
  parameter int INTLV_STAGES = 2,
  parameter int NTT_LAT      = 7,
  parameter int INTT_LAT     = 13
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mode,
  output logic               sel,
  output logic [1:0]         sel_a_0,
  output logic [1:0]         sel_a_1,
  output logic [1:0]         sel_a_2,
  output logic [1:0]         sel_a_3,
  output logic               issue_valid,
  output logic [GRP_W-1:0]   grp_idx,
  output logic [STAGE_W-1:0] stage_idx,
  output logic               busy,
  output logic               done
`ifdef BF_OUT_SCHED_STALL_EN
  ,
  input  logic               hold
`endif
);

  localparam int MAX_LAT = (NTT_LAT > INTT_LAT) ? NTT_LAT : INTT_LAT;
  localparam int LAT_W   = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;

  localparam logic [STAGE_W-1:0] ILV_LO     = STAGE_W'(INTLV_STAGES);
  localparam logic [STAGE_W-1:0] ILV_HI     = STAGE_W'(NUM_STAGES - INTLV_STAGES);
  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);
  localparam logic [LAT_W-1:0]   NTT_LOAD   = LAT_W'(NTT_LAT - 1);
  localparam logic [LAT_W-1:0]   INTT_LOAD  = LAT_W'(INTT_LAT - 1);

  localparam logic [3:0][1:0] PAT_STR = 8'b01_00_11_10;
  localparam logic [3:0][1:0] PAT_ILV = 8'b01_11_00_10;

  typedef enum logic [1:0] {IDLE, RUN, GAP, DRAIN} state_t;

  state_t             state;
  logic [LAT_W-1:0]   lat_cnt;
  logic [3:0][1:0]    route_q;
  logic               issue_q;
  logic               adv;
  logic [STAGE_W-1:0] stage_nxt;

  // NTT interleaves the last stages, INTT the first ones
  function automatic logic [3:0][1:0] route(input logic [STAGE_W-1:0] s, input logic m);
    logic ilv;
    ilv = m ? (s < ILV_LO) : (s >= ILV_HI);
    return ilv ? PAT_ILV : PAT_STR;
  endfunction

`ifdef BF_OUT_SCHED_STALL_EN
  assign adv         = ~hold;
  assign issue_valid = issue_q & ~hold;
`else
  assign adv         = 1'b1;
  assign issue_valid = issue_q;
`endif

  assign stage_nxt = stage_idx + 1'b1;
  assign {sel_a_0, sel_a_1, sel_a_2, sel_a_3} = route_q;

  // Registers hold the values for the coming cycle, so the first issue is
  // visible right after the edge that samples start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      route_q   <= PAT_STR;
      issue_q   <= 1'b0;
      sel       <= 1'b0;
      grp_idx   <= '0;
      stage_idx <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !done) begin
            sel       <= mode;
            grp_idx   <= '0;
            stage_idx <= '0;
            route_q   <= route('0, mode);
            issue_q   <= 1'b1;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          if (adv) begin
            if (grp_idx == '1) begin
              grp_idx <= '0;
              lat_cnt <= sel ? INTT_LOAD : NTT_LOAD;
              issue_q <= 1'b0;
              state   <= (stage_idx == LAST_STAGE) ? DRAIN : GAP;
            end else begin
              grp_idx <= grp_idx + 1'b1;
            end
          end
        end
        GAP: begin
          if (lat_cnt == '0) begin
            stage_idx <= stage_nxt;
            route_q   <= route(stage_nxt, sel);
            issue_q   <= 1'b1;
            state     <= RUN;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        DRAIN: begin
          if (lat_cnt == '0) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bf_out_route_sched.sv
// Scoreboard bench for bf_out_route_sched (GRP_W=2, 3 stages, 1 interleaved stage, 7/13 latency).
module tb_bf_out_route_sched;
  localparam int GRPS = 4, NST = 3, NTT = 7, INTT = 13;
  localparam logic [7:0] STR = 8'b01_00_11_10;
  localparam logic [7:0] ILV = 8'b01_11_00_10;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, mode = 1'b0, hold = 1'b0;
  logic sel, issue_valid, busy, done;
  logic [1:0] sel_a_0, sel_a_1, sel_a_2, sel_a_3;
  logic [1:0] grp_idx, stage_idx;
  logic [7:0] rt;
  assign rt = {sel_a_0, sel_a_1, sel_a_2, sel_a_3};

  bf_out_route_sched #(
    .GRP_W(2), .NUM_STAGES(3), .STAGE_W(2), .INTLV_STAGES(1), .NTT_LAT(NTT), .INTT_LAT(INTT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .sel(sel),
    .sel_a_0(sel_a_0), .sel_a_1(sel_a_1), .sel_a_2(sel_a_2), .sel_a_3(sel_a_3),
    .issue_valid(issue_valid), .grp_idx(grp_idx), .stage_idx(stage_idx),
    .busy(busy), .done(done)
`ifdef BF_OUT_SCHED_STALL_EN
    , .hold(hold)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0, checks = 0;

  typedef struct {
    int cyc; int grp; int stg; logic sel; logic [7:0] rt;
  } iss_t;
  iss_t iq[$];
  int   dq[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected issue and done cycles for a pass whose first issue is at base.
  // A hold of hold_len cycles at stage 0 group 2 shifts everything from there on.
  task automatic push_pass(input int base, input logic m, input int hold_len);
    int lat, off;
    iss_t e;
    lat = m ? INTT : NTT;
    for (int s = 0; s < NST; s++)
      for (int g = 0; g < GRPS; g++) begin
        off = s * (GRPS + lat) + g;
        if (hold_len > 0 && (s > 0 || g >= 2)) off += hold_len;
        e.cyc = base + off; e.grp = g; e.stg = s; e.sel = m;
        e.rt  = (m ? (s == 0) : (s == 2)) ? ILV : STR;
        iq.push_back(e);
      end
    dq.push_back(base + NST * (GRPS + lat) + hold_len);
  endtask

  task automatic run_pass(input logic m, input int hold_len);
    int base;
    @(negedge clk);
    start = 1'b1; mode = m;
    base = cyc + 1;
    push_pass(base, m, hold_len);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done) break;
    end
    chk({name, "_done_seen"}, int'(k < 300), 1);
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_sel"},   sel, 0);
    chk({name, "_route"}, rt, STR);
    chk({name, "_issue"}, issue_valid, 0);
    chk({name, "_grp"},   grp_idx, 0);
    chk({name, "_stage"}, stage_idx, 0);
    chk({name, "_busy"},  busy, 0);
    chk({name, "_done"},  done, 0);
  endtask

  // Monitor: every issue and done pulse is matched against the scoreboard.
  iss_t e;
  always @(negedge clk) begin
    if (!rst) begin
      if (issue_valid) begin
        chk("issue_expected", int'(iq.size() > 0), 1);
        if (iq.size() > 0) begin
          e = iq.pop_front();
          chk("issue_cyc", cyc, e.cyc);
          chk("grp_idx", grp_idx, e.grp);
          chk("stage_idx", stage_idx, e.stg);
          chk("sel", sel, e.sel);
          chk("route", rt, e.rt);
          chk("busy_in_run", busy, 1);
        end
      end
      if (done) begin
        chk("done_expected", int'(dq.size() > 0), 1);
        if (dq.size() > 0) chk("done_cyc", cyc, dq.pop_front());
        chk("busy_at_done", busy, 0);
      end
    end
  end

  initial begin
    int k;
    // 1: reset values, then idle without start
    repeat (3) @(negedge clk);
    chk_reset_vals("in_reset");
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("idle_busy", busy, 0);
    end
    chk_reset_vals("idle");

    // 2: NTT pass
    run_pass(1'b0, 0);
    wait_done("ntt");
    @(negedge clk);
    chk("ntt_busy_after", busy, 0);

    // 3: INTT pass
    run_pass(1'b1, 0);
    wait_done("intt");

    // 4: start and mode changes mid-pass ignored; start on done ignored, next cycle accepted
    run_pass(1'b0, 0);
    repeat (5) @(negedge clk);
    start = 1'b1; mode = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      mode = ~mode;
    end
    wait_done("busy_start");
    start = 1'b1; mode = 1'b1;
    run_pass(1'b1, 0);
    wait_done("post_done_start");

    // 5: reset during stage 1 RUN aborts the pass
    run_pass(1'b0, 0);
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (issue_valid && stage_idx == 2'd1) break;
    end
    chk("reach_stage1", int'(k < 100), 1);
    #2 rst = 1'b1;
    #1 chk_reset_vals("async_rst");
    iq.delete(); dq.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort_busy", busy, 0);
    run_pass(1'b1, 0);
    wait_done("after_abort");

`ifdef BF_OUT_SCHED_STALL_EN
    // 6: three-cycle hold at stage 0 group 2
    run_pass(1'b0, 3);
    @(posedge clk);
    @(posedge clk);
    #1 hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_issue", issue_valid, 0);
      chk("hold_grp", grp_idx, 2);
    end
    @(posedge clk);
    #1 hold = 1'b0;
    wait_done("stall");
`endif

    repeat (5) @(negedge clk);
    chk("issue_queue_empty", iq.size(), 0);
    chk("done_queue_empty", dq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
